// File: rtl/psum_drain_collector.sv
// psum_drain_collector
//   Drains the partial sums out of an output-stationary systolic array once a
//   tile's compute phase is complete. It asserts the array's shift-out enable,
//   captures S_WIDTH columns arriving on the row outputs, pulses the array's
//   register clear, then streams the captured columns downstream, one column
//   (S_HEIGHT psums) per valid/ready beat.
//
// Ports
//   i_clk, i_nrst   clock (rising edge), asynchronous active-low reset
//   i_start         1-cycle pulse: psums final, begin drain (ignored while busy)
//   i_psum          array row outputs, row 0 in lane 0
//   o_psum_out_en   shift-out enable to the array
//   o_reg_clear     1-cycle clear pulse to the array PEs
//   o_busy          high whenever the FSM is not idle
//   o_valid/i_ready output beat handshake
//   o_data          one captured column, row 0 in lane 0
//   o_col_idx       column index of o_data
//   o_last          high with the final column beat
//
// Configuration
//   PSUM_DRAIN_RELU_EN  when defined, negative o_data lanes are driven as zero;
//                       the buffer still holds raw psums.

module psum_drain_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int S_WIDTH    = 2,
    parameter int S_HEIGHT   = 2,
    parameter int ARRAY_LAT  = 1,
    localparam int PW        = 2 * DATA_WIDTH,
    localparam int COL_W     = (S_WIDTH > 1) ? $clog2(S_WIDTH) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic                         i_start,
    input  logic [S_HEIGHT-1:0][PW-1:0]  i_psum,
    output logic                         o_psum_out_en,
    output logic                         o_reg_clear,
    output logic                         o_busy,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [S_HEIGHT-1:0][PW-1:0]  o_data,
    output logic [COL_W-1:0]             o_col_idx,
    output logic                         o_last
);

    localparam int CNT_W = $clog2(S_WIDTH + ARRAY_LAT + 1);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(S_WIDTH + ARRAY_LAT - 1);
    localparam logic [CNT_W-1:0] EN_END     = CNT_W'(S_WIDTH);
    localparam logic [CNT_W-1:0] LAT_C      = CNT_W'(ARRAY_LAT);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(S_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CLEAR,
        ST_SEND
    } state_t;

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             cnt;
    logic [COL_W-1:0]             col;
    logic [S_HEIGHT-1:0][PW-1:0]  buffer [S_WIDTH];
    logic [S_HEIGHT-1:0][PW-1:0]  col_sel;

    // state register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == SHIFT_LAST) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_SEND;
            ST_SEND:  if (i_ready && (col == COL_LAST)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // cycle counter, column pointer and capture buffer
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cnt <= '0;
            col <= '0;
            for (int unsigned i = 0; i < S_WIDTH; i++) buffer[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    col <= '0;
                end
                ST_SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    // column k arrives ARRAY_LAT cycles after its enable cycle
                    for (int unsigned i = 0; i < S_WIDTH; i++) begin
                        if ((cnt >= LAT_C) && ((cnt - LAT_C) == CNT_W'(i)))
                            buffer[i] <= i_psum;
                    end
                end
                ST_SEND: begin
                    if (i_ready)
                        col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
                end
                default: ;
            endcase
        end
    end

    // output logic (Moore: no path from i_ready to o_valid)
    always_comb begin
        col_sel = '0;
        for (int unsigned i = 0; i < S_WIDTH; i++) begin
            if (col == COL_W'(i)) col_sel = buffer[i];
        end

        o_psum_out_en = (state == ST_SHIFT) && (cnt < EN_END);
        o_reg_clear   = (state == ST_CLEAR);
        o_busy        = (state != ST_IDLE);
        o_valid       = (state == ST_SEND);
        o_last        = (state == ST_SEND) && (col == COL_LAST);
        o_col_idx     = col;

`ifdef PSUM_DRAIN_RELU_EN
        o_data = col_sel;
        for (int unsigned h = 0; h < S_HEIGHT; h++) begin
            if (col_sel[h][PW-1]) o_data[h] = '0;
        end
`else
        o_data = col_sel;
`endif
    end

endmodule

// File: tb/tb_psum_drain_collector.sv
module tb_psum_drain_collector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ready = 1'b1;
    logic start1 = 1'b0;
    logic start3 = 1'b0;

    logic [1:0][15:0] psum1, psum3, data1, data3;
    logic en1, clr1, busy1, valid1, last1, col1;
    logic en3, clr3, busy3, valid3, last3, col3;

    int total = 0;
    int bad = 0;

    logic [31:0] cols1 [2];
    logic [31:0] cols3 [2];
    logic [31:0] pipe3 [3];
    int k1 = 0;
    int k3 = 0;

    logic [15:0] en_exp, clr_exp, valid_exp, busy_exp;
    int beats, clears, ens;

    always #5 clk = ~clk;

    psum_drain_collector #(.DATA_WIDTH(8), .S_WIDTH(2), .S_HEIGHT(2), .ARRAY_LAT(1)) u_dut1 (
        .i_clk(clk), .i_nrst(rst_n), .i_start(start1), .i_psum(psum1),
        .o_psum_out_en(en1), .o_reg_clear(clr1), .o_busy(busy1), .o_valid(valid1),
        .i_ready(ready), .o_data(data1), .o_col_idx(col1), .o_last(last1)
    );

    psum_drain_collector #(.DATA_WIDTH(8), .S_WIDTH(2), .S_HEIGHT(2), .ARRAY_LAT(3)) u_dut3 (
        .i_clk(clk), .i_nrst(rst_n), .i_start(start3), .i_psum(psum3),
        .o_psum_out_en(en3), .o_reg_clear(clr3), .o_busy(busy3), .o_valid(valid3),
        .i_ready(ready), .o_data(data3), .o_col_idx(col3), .o_last(last3)
    );

    // array models: column k appears ARRAY_LAT cycles after the k-th enable cycle
    always @(posedge clk) begin
        if (start1) k1 <= 0;
        else if (en1) k1 <= k1 + 1;
        psum1 <= (en1 && k1 < 2) ? cols1[k1[0]] : 32'hDEADBEEF;
    end

    always @(posedge clk) begin
        if (start3) k3 <= 0;
        else if (en3) k3 <= k3 + 1;
        pipe3[0] <= (en3 && k3 < 2) ? cols3[k3[0]] : 32'hDEADBEEF;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign psum3 = pipe3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // returns at the sampling point of cycle 1
    task automatic pulse_start1();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
    endtask

    task automatic pulse_start3();
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
    endtask

    initial begin
        cols1[0] = {16'd20, 16'd10};
        cols1[1] = {16'd40, 16'd30};
        cols3[0] = {16'd222, 16'd111};
        cols3[1] = {16'd444, 16'd333};
        pipe3[0] = 32'hDEADBEEF;
        pipe3[1] = 32'hDEADBEEF;
        pipe3[2] = 32'hDEADBEEF;
        psum1 = 32'hDEADBEEF;

        // reset state
        #12;
        check("rst busy", 32'(busy1), 32'd0);
        check("rst valid", 32'(valid1), 32'd0);
        check("rst en", 32'(en1), 32'd0);
        check("rst clr", 32'(clr1), 32'd0);
        check("rst data", 32'(data1), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: reset mid-SHIFT at cnt=1
        pulse_start1();
        @(negedge clk);
        check("t1 pre busy", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1 busy", 32'(busy1), 32'd0);
        check("t1 en", 32'(en1), 32'd0);
        check("t1 clr", 32'(clr1), 32'd0);
        check("t1 valid", 32'(valid1), 32'd0);
        check("t1 data", 32'(data1), 32'd0);
        check("t1 col", 32'(col1), 32'd0);
        check("t1 last", 32'(last1), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2: basic drain, ready held high
        en_exp    = 16'b0000_0000_0000_0110;
        clr_exp   = 16'b0000_0000_0001_0000;
        valid_exp = 16'b0000_0000_0110_0000;
        busy_exp  = 16'b0000_0000_0111_1110;
        ready = 1'b1;
        pulse_start1();
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("t2 en c%0d", c), 32'(en1), 32'(en_exp[c]));
            check($sformatf("t2 clr c%0d", c), 32'(clr1), 32'(clr_exp[c]));
            check($sformatf("t2 valid c%0d", c), 32'(valid1), 32'(valid_exp[c]));
            check($sformatf("t2 busy c%0d", c), 32'(busy1), 32'(busy_exp[c]));
            if (c == 5) begin
                check("t2 data0", 32'(data1), cols1[0]);
                check("t2 col0", 32'(col1), 32'd0);
                check("t2 last0", 32'(last1), 32'd0);
            end
            if (c == 6) begin
                check("t2 data1", 32'(data1), cols1[1]);
                check("t2 col1", 32'(col1), 32'd1);
                check("t2 last1", 32'(last1), 32'd1);
            end
        end

        // 3: backpressure for 3 cycles on col0
        ready = 1'b0;
        pulse_start1();
        repeat (4) @(negedge clk);
        for (int c = 5; c <= 7; c++) begin
            if (c > 5) @(negedge clk);
            check($sformatf("t3 valid c%0d", c), 32'(valid1), 32'd1);
            check($sformatf("t3 data c%0d", c), 32'(data1), cols1[0]);
            check($sformatf("t3 col c%0d", c), 32'(col1), 32'd0);
            check($sformatf("t3 last c%0d", c), 32'(last1), 32'd0);
        end
        ready = 1'b1;
        @(negedge clk);
        check("t3 data1", 32'(data1), cols1[1]);
        check("t3 col1", 32'(col1), 32'd1);
        check("t3 last1", 32'(last1), 32'd1);
        @(negedge clk);
        check("t3 idle", 32'(busy1), 32'd0);
        check("t3 novalid", 32'(valid1), 32'd0);

        // 4: start during SEND is ignored
        beats = 0; clears = 0; ens = 0;
        pulse_start1();
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            if (valid1 && ready) beats++;
            if (clr1) clears++;
            if (en1) ens++;
            if (c == 5) start1 = 1'b1;
            if (c == 6) start1 = 1'b0;
        end
        check("t4 beats", 32'(beats), 32'd2);
        check("t4 clears", 32'(clears), 32'd1);
        check("t4 ens", 32'(ens), 32'd2);
        check("t4 idle", 32'(busy1), 32'd0);

        // 5: ARRAY_LAT=3 instance
        en_exp    = 16'b0000_0000_0000_0110;
        clr_exp   = 16'b0000_0000_0100_0000;
        valid_exp = 16'b0000_0001_1000_0000;
        busy_exp  = 16'b0000_0001_1111_1110;
        pulse_start3();
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("t5 en c%0d", c), 32'(en3), 32'(en_exp[c]));
            check($sformatf("t5 clr c%0d", c), 32'(clr3), 32'(clr_exp[c]));
            check($sformatf("t5 valid c%0d", c), 32'(valid3), 32'(valid_exp[c]));
            check($sformatf("t5 busy c%0d", c), 32'(busy3), 32'(busy_exp[c]));
            if (c == 7) begin
                check("t5 data0", 32'(data3), cols3[0]);
                check("t5 last0", 32'(last3), 32'd0);
            end
            if (c == 8) begin
                check("t5 data1", 32'(data3), cols3[1]);
                check("t5 col1", 32'(col3), 32'd1);
                check("t5 last1", 32'(last3), 32'd1);
            end
        end

        // 6: negative psum lanes
        cols1[0] = {16'd5, 16'hFF9C};
        cols1[1] = {16'd7, 16'h8000};
        pulse_start1();
        repeat (4) @(negedge clk);
`ifdef PSUM_DRAIN_RELU_EN
        check("t6 data0", 32'(data1), {16'd5, 16'h0000});
        @(negedge clk);
        check("t6 data1", 32'(data1), {16'd7, 16'h0000});
`else
        check("t6 data0", 32'(data1), {16'd5, 16'hFF9C});
        @(negedge clk);
        check("t6 data1", 32'(data1), {16'd7, 16'h8000});
`endif
        @(negedge clk);
        check("t6 idle", 32'(busy1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
